// File: rtl/hazard_scoreboard_unit.sv
// RAW-hazard unit: EX operand forwarding select, load scoreboard with load-use stall,
// and a stall watchdog. Optional perf counters under `ifdef HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit #(
  parameter int REGW    = 5,
  parameter int NRS     = 2,
  parameter int NFWD    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NRS*REGW-1:0]            rs_d_i,
  input  logic [NRS*REGW-1:0]            rs_e_i,
  input  logic [NFWD*REGW-1:0]           rd_fwd_i,
  input  logic [NFWD-1:0]                we_fwd_i,
  input  logic                           ld_issue_i,
  input  logic [REGW-1:0]                ld_rd_i,
  input  logic                           ld_done_i,
  input  logic [REGW-1:0]                ld_done_rd_i,
  output logic [NRS*$clog2(NFWD+1)-1:0]  fwd_sel_o,
  output logic                           stall_o,
  output logic                           sb_busy_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]                    perf_stall_o,
  output logic [31:0]                    perf_fwd_o,
`endif
  output logic                           err_o
);

  localparam int SW   = $clog2(NFWD + 1);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int NREG = 2 ** REGW;
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic {RUN, STALL} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic [NREG-1:0] sb_q, sb_d;
  logic            sb_busy_q;
  logic            stall;
  logic [REGW-1:0] rs_dec;
  logic [REGW-1:0] rs_ex;
  logic [SW-1:0]   sel;

  // Descending scan so the lowest-index (youngest) matching source wins.
  always_comb begin
    fwd_sel_o = '0;
    rs_ex     = '0;
    sel       = '0;
    for (int j = 0; j < NRS; j++) begin
      rs_ex = rs_e_i[j*REGW +: REGW];
      sel   = '0;
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (we_fwd_i[k] && (rd_fwd_i[k*REGW +: REGW] == rs_ex) && (rs_ex != '0))
          sel = SW'(k + 1);
      end
      fwd_sel_o[j*SW +: SW] = sel;
    end
  end

  // A load returning this cycle bypasses its own scoreboard bit.
  always_comb begin
    stall  = 1'b0;
    rs_dec = '0;
    for (int j = 0; j < NRS; j++) begin
      rs_dec = rs_d_i[j*REGW +: REGW];
      if (rs_dec != '0) begin
        if (sb_q[rs_dec] && !(ld_done_i && (ld_done_rd_i == rs_dec)))
          stall = 1'b1;
        if (ld_issue_i && (ld_rd_i == rs_dec))
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (ld_done_i)
      sb_d[ld_done_rd_i] = 1'b0;
    if (ld_issue_i && (ld_rd_i != '0))
      sb_d[ld_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      sb_q      <= '0;
      sb_busy_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      sb_busy_q <= |sb_d;
      case (state_q)
        RUN: begin
          if (stall) begin
            state_q <= STALL;
            cnt_q   <= CW'(1);
          end
        end
        STALL: begin
          if (stall) begin
            if (cnt_q != TO_C)
              cnt_q <= cnt_q + CW'(1);
            if (cnt_q >= TO_C - CW'(1))
              err_q <= 1'b1;
          end else begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stall_o   = stall;
  assign sb_busy_o = sb_busy_q;
  assign err_o     = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_fwd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      if (stall)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (|fwd_sel_o)
        perf_fwd_q <= perf_fwd_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_fwd_o   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (TIMEOUT=4): forwarding priority, load-use,
// set/clear collision, watchdog, async reset, and perf counters when HAZARD_PERF_CNT_EN is set.
module tb_hazard_scoreboard_unit;

  localparam int REGW = 5;
  localparam int NRS  = 2;
  localparam int NFWD = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NRS*REGW-1:0]  rs_d_i, rs_e_i;
  logic [NFWD*REGW-1:0] rd_fwd_i;
  logic [NFWD-1:0]      we_fwd_i;
  logic                 ld_issue_i, ld_done_i;
  logic [REGW-1:0]      ld_rd_i, ld_done_rd_i;
  logic [3:0]           fwd_sel_o;
  logic                 stall_o, sb_busy_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]          perf_stall_o, perf_fwd_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  hazard_scoreboard_unit #(.REGW(REGW), .NRS(NRS), .NFWD(NFWD), .TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rs_d_i       (rs_d_i),
    .rs_e_i       (rs_e_i),
    .rd_fwd_i     (rd_fwd_i),
    .we_fwd_i     (we_fwd_i),
    .ld_issue_i   (ld_issue_i),
    .ld_rd_i      (ld_rd_i),
    .ld_done_i    (ld_done_i),
    .ld_done_rd_i (ld_done_rd_i),
    .fwd_sel_o    (fwd_sel_o),
    .stall_o      (stall_o),
    .sb_busy_o    (sb_busy_o),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_o (perf_stall_o),
    .perf_fwd_o   (perf_fwd_o),
`endif
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    rs_d_i = '0; rs_e_i = '0; rd_fwd_i = '0; we_fwd_i = '0;
    ld_issue_i = 1'b0; ld_rd_i = '0; ld_done_i = 1'b0; ld_done_rd_i = '0;
    #3;
    check("rst_sb_busy", sb_busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_fwd", fwd_sel_o, 0);
    #9 rst_ni = 1'b1;
    tick();

    // Forwarding priority
    we_fwd_i = 2'b11; rd_fwd_i = {5'd5, 5'd5}; rs_e_i = {5'd5, 5'd5};
    #1 check("fwd_both_src0", fwd_sel_o, 4'b0101);
    rs_e_i = '0;
    #1 check("fwd_x0", fwd_sel_o, 4'b0000);
    we_fwd_i = 2'b10; rd_fwd_i = {5'd6, 5'd6}; rs_e_i = {5'd6, 5'd6};
    #1 check("fwd_both_src1", fwd_sel_o, 4'b1010);
    we_fwd_i = 2'b11; rd_fwd_i = {5'd6, 5'd5}; rs_e_i = {5'd6, 5'd5};
    #1 check("fwd_mixed", fwd_sel_o, 4'b1001);
    we_fwd_i = 2'b00;
    #1 check("fwd_no_we", fwd_sel_o, 4'b0000);
    rs_e_i = '0; rd_fwd_i = '0;

    // Load-use
    tick();
    ld_issue_i = 1'b1; ld_rd_i = 5'd7; rs_d_i = {5'd0, 5'd7};
    #1 check("lu_stall_c1", stall_o, 1);
    check("lu_busy_c1", sb_busy_o, 0);
    tick();
    ld_issue_i = 1'b0; ld_rd_i = '0;
    #1 check("lu_stall_c2", stall_o, 1);
    check("lu_busy_c2", sb_busy_o, 1);
    tick();
    ld_done_i = 1'b1; ld_done_rd_i = 5'd7;
    #1 check("lu_bypass_c3", stall_o, 0);
    tick();
    ld_done_i = 1'b0; ld_done_rd_i = '0;
    #1 check("lu_busy_after", sb_busy_o, 0);
    check("lu_stall_after", stall_o, 0);
    check("lu_err", err_o, 0);
    rs_d_i = '0;

    // Set/clear collision on r9, then x0 load ignored
    ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    tick();
    ld_done_i = 1'b1; ld_done_rd_i = 5'd9;
    tick();
    ld_issue_i = 1'b0; ld_done_i = 1'b0;
    rs_d_i = {5'd9, 5'd0};
    #1 check("col_busy", sb_busy_o, 1);
    check("col_stall", stall_o, 1);
    ld_done_i = 1'b1;
    #1 check("col_bypass", stall_o, 0);
    tick();
    ld_done_i = 1'b0; rs_d_i = '0;
    #1 check("col_cleared", sb_busy_o, 0);
    ld_issue_i = 1'b1; ld_rd_i = 5'd0;
    #1 check("x0_no_stall", stall_o, 0);
    tick();
    ld_issue_i = 1'b0;
    #1 check("x0_ignored", sb_busy_o, 0);

    // Watchdog
    ld_issue_i = 1'b1; ld_rd_i = 5'd3;
    tick();
    ld_issue_i = 1'b0; rs_d_i = {5'd3, 5'd0};
    #1 check("wd_stall", stall_o, 1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("wd_err_edge%0d", e), err_o, 0);
    end
    tick();
    check("wd_err_edge4", err_o, 1);
    check("wd_stall_kept", stall_o, 1);
    ld_done_i = 1'b1; ld_done_rd_i = 5'd3;
    tick();
    ld_done_i = 1'b0;
    #1 check("wd_stall_clear", stall_o, 0);
    check("wd_sticky", err_o, 1);
    tick();
    check("wd_sticky2", err_o, 1);

    // Async reset mid-stall
    ld_issue_i = 1'b1; ld_rd_i = 5'd3;
    tick();
    ld_issue_i = 1'b0;
    #1 check("ar_pre_busy", sb_busy_o, 1);
    check("ar_pre_stall", stall_o, 1);
    #1 rst_ni = 1'b0;
    #1 check("ar_busy", sb_busy_o, 0);
    check("ar_err", err_o, 0);
    check("ar_stall", stall_o, 0);
    #2 rst_ni = 1'b1;
    tick();
    check("ar_post_stall", stall_o, 0);
    check("ar_post_busy", sb_busy_o, 0);

`ifdef HAZARD_PERF_CNT_EN
    rs_d_i = '0;
    #1 rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    check("perf_rst_stall", perf_stall_o, 0);
    check("perf_rst_fwd", perf_fwd_o, 0);
    tick();
    ld_issue_i = 1'b1; ld_rd_i = 5'd3; rs_d_i = {5'd0, 5'd3};
    tick();
    ld_issue_i = 1'b0;
    tick();
    tick();
    ld_done_i = 1'b1; ld_done_rd_i = 5'd3;
    tick();
    ld_done_i = 1'b0; rs_d_i = '0;
    we_fwd_i = 2'b01; rd_fwd_i = {5'd0, 5'd4}; rs_e_i = {5'd0, 5'd4};
    tick();
    tick();
    we_fwd_i = '0; rs_e_i = '0;
    tick();
    check("perf_stall", perf_stall_o, 3);
    check("perf_fwd", perf_fwd_o, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
